uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter clk_freq, default 12000000, system clock frequency in Hz.
REQ-002 Parameter baud, default 115200, line bit rate in bit/s.
REQ-003 Parameter fifo_depth, default 4, transmit FIFO entries; power of two, >= 2.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  write strobe; byte on din offered this cycle.
REQ-007 din  input  8  byte to transmit.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 full  output  1  FIFO holds fifo_depth entries.
REQ-010 empty  output  1  FIFO holds 0 entries.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 ovf  output  1  one-cycle pulse when a write is dropped.

Function
REQ-013 Bit period DIV SHALL be clk_freq/baud, truncated to an integer (104 at the defaults); an internal counter SHALL count 0..DIV-1, clear on every state entry, and emit a bit-end tick when it reaches DIV-1.
REQ-014 Frame format SHALL be 8N1: start bit 0, data bits d0..d7 (LSB first), stop bit 1; each bit SHALL be held for exactly DIV cycles.
REQ-015 A write SHALL be accepted iff wr_en=1 and full=0 in the same cycle; FIFO count and write pointer SHALL update on that edge.
REQ-016 A write with full=1 SHALL be dropped without disturbing FIFO contents, and ovf SHALL be 1 for the following cycle only; a pop in the same cycle does not rescue the write.
REQ-017 full and empty SHALL be derived from the registered count (width log2(fifo_depth)+1); pointers SHALL wrap modulo fifo_depth.
REQ-018 A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-019 FSM states: IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1; if empty=0, pop the head into the shift register and enter START on the same edge, so tx=0 one cycle after the pop decision.
REQ-021 START: tx=0 for DIV cycles, then enter DATA with bit index 0.
REQ-022 DATA: tx=shift[0]; on each tick, shift right and increment the 3-bit index; after the tick at index 7, enter STOP.
REQ-023 STOP: tx=1 for DIV cycles; on the tick, if empty=0, pop and enter START directly (no idle gap between frames); otherwise enter IDLE.
REQ-024 A write to an empty FIFO while the FSM is in IDLE SHALL produce a tx falling edge exactly 2 clock edges after the write edge (write edge, then pop edge).
REQ-025 The FIFO SHALL only be popped in IDLE or at the STOP tick; it SHALL never be popped when empty.
REQ-026 tx SHALL be driven from a flop: no combinational path from din or wr_en to tx.

Reset
REQ-027 While rst=1: state=IDLE, tx=1, busy=0, count=0, both pointers=0, empty=1, full=0, ovf=0, and the baud counter and bit index cleared.
REQ-028 rst asserted mid-frame SHALL abort the frame and drive tx=1 at the next edge; queued bytes SHALL be discarded (not sent after reset).
REQ-029 wr_en while rst=1 SHALL be ignored and SHALL NOT raise ovf.

Verification
REQ-030 Single byte at default parameters: write 0x55 into an idle block -> tx reads 0,1,0,1,0,1,0,1,0,1, each held 104 cycles; busy high for 1040 cycles; then IDLE with tx=1 and empty=1.
REQ-031 Back-to-back: write 0xA5 then 0x3C on consecutive cycles -> two frames totalling 2080 cycles, the second start bit immediately following the first stop bit; decoded bytes are 0xA5 then 0x3C.
REQ-032 Overflow with fifo_depth=4: write 0x01..0x06 on six consecutive cycles into an idle block -> 0x01..0x05 accepted (0x01 popped on the second edge), full=1 after the fifth write, 0x06 dropped with a single ovf pulse; line carries 0x01..0x05 in order.
REQ-033 Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0xF0 with 2 bytes queued -> tx=1 next cycle, empty=1, busy=0; line stays high until the next write.
REQ-034 Pointer wrap: stream 10 bytes 0x10..0x19, each written while full=0 -> all 10 transmitted in order with no gaps or duplicates; empty=1 after the last stop bit.
REQ-035 Divisor check with clk_freq=1000 and baud=300 -> DIV=3; each bit is held exactly 3 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small power-of-two byte FIFO.
// The line is driven from a flop; frames go out back-to-back while the
// FIFO has data, and writes into a full FIFO are dropped with an ovf pulse.
module uart_tx #(
    parameter int clk_freq   = 12000000,
    parameter int baud       = 115200,
    parameter int fifo_depth = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       tx,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf
);

    // Bit period in clocks; truncating division.
    localparam int DIV = clk_freq / baud;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int NW  = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   baud_cnt, baud_cnt_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shift, shift_d;
    logic            tx_d;

    logic [7:0]      mem [fifo_depth];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic            push, pop, tick;

    // Flags come straight from the registered occupancy count.
    assign full  = (count == NW'(fifo_depth));
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // A pop never rescues a write: acceptance looks only at full.
    assign push  = wr_en && !full;
    assign tick  = (baud_cnt == CW'(DIV - 1));

    // Next-state, pop decision, bit timing and next line level.
    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        pop       = 1'b0;
        tx_d      = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on every state entry and at each bit end.
        if (state_d != state || state == IDLE || tick) baud_cnt_d = '0;
        else                                          baud_cnt_d = baud_cnt + CW'(1);

        // Line level is decided from where we will be after this edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Transmit FSM and line register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            tx       <= tx_d;
        end
    end

    // FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= wr_en && full;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= din;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: instance A at default parameters runs table-driven single
// frames plus a back-to-back pair; instance B (clk_freq=1000, baud=300,
// three clocks per bit) runs corner sequences and random traffic against a
// queue-and-countdown model of the transmitter.
module tb_uart_tx;

    localparam int DIV_A = 104;
    localparam int DIV_B = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, wr_a = 1'b0;
    logic [7:0] din_a = '0;
    logic       tx_a, full_a, empty_a, busy_a, ovf_a;
    logic       rst_b = 1'b1, wr_b = 1'b0;
    logic [7:0] din_b = '0;
    logic       tx_b, full_b, empty_b, busy_b, ovf_b;

    uart_tx dut_a (
        .clk(clk), .rst(rst_a), .wr_en(wr_a), .din(din_a),
        .tx(tx_a), .full(full_a), .empty(empty_a), .busy(busy_a), .ovf(ovf_a)
    );

    uart_tx #(.clk_freq(1000), .baud(300), .fifo_depth(DEPTH)) dut_b (
        .clk(clk), .rst(rst_b), .wr_en(wr_b), .din(din_b),
        .tx(tx_b), .full(full_b), .empty(empty_b), .busy(busy_b), .ovf(ovf_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line images: bit i is the i-th bit on the wire (start, d0..d7, stop).
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;
    vec_t tbl[7];

    // Check nfr consecutive frames on line A starting at frame cycle 0.
    task automatic run_a(input string name, input int nfr, input logic [9:0] f0, input logic [9:0] f1);
        int bad, nbusy, fi, c, b;
        logic [9:0] f;
        logic [7:0] dec [2];
        bad = 0; nbusy = 0;
        dec[0] = '0; dec[1] = '0;
        for (int k = 0; k < nfr * 10 * DIV_A; k++) begin
            fi = k / (10 * DIV_A);
            c  = k % (10 * DIV_A);
            b  = c / DIV_A;
            f  = (fi == 0) ? f0 : f1;
            if (tx_a !== f[b]) bad++;
            if (busy_a === 1'b1) nbusy++;
            if ((c % DIV_A) == DIV_A / 2 && b >= 1 && b <= 8) dec[fi][b-1] = tx_a;
            @(negedge clk);
        end
        chk({name, " line"}, bad, 0);
        chk({name, " busy cycles"}, nbusy, nfr * 10 * DIV_A);
        chk({name, " byte0"}, dec[0], f0[8:1]);
        if (nfr > 1) chk({name, " byte1"}, dec[1], f1[8:1]);
        chk({name, " idle after"}, {tx_a, busy_a, empty_a, full_a}, 4'b1010);
    endtask

    // Reference model for B: byte queue plus cycles left in current frame.
    logic [7:0] mq[$];
    int         rem   = 0;
    logic [7:0] cur   = '0;
    logic       m_ovf = 1'b0;

    function automatic logic m_tx();
        int idx;
        if (rem == 0) return 1'b1;
        idx = (10 * DIV_B - rem) / DIV_B;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return cur[idx-1];
    endfunction

    task automatic model_edge(input logic w, input logic [7:0] d, input logic r);
        int sz;
        if (r) begin
            mq.delete();
            rem   = 0;
            m_ovf = 1'b0;
        end else begin
            sz    = mq.size();
            m_ovf = w && (sz == DEPTH);
            if (rem <= 1 && sz > 0) begin
                cur = mq.pop_front();
                rem = 10 * DIV_B;
            end else if (rem > 0) begin
                rem--;
            end
            if (w && sz < DEPTH) mq.push_back(d);
        end
    endtask

    // Independent receiver on line B, sampling mid-bit.
    int         rx_cnt = 0;
    logic [7:0] rx_sh  = '0;
    logic [7:0] rx_q[$];

    task automatic decode_b(input logic r);
        int b;
        if (r) begin
            rx_cnt = 0;
        end else if (rx_cnt == 0) begin
            if (tx_b === 1'b0) rx_cnt = 1;
        end else begin
            if (rx_cnt % DIV_B == DIV_B / 2) begin
                b = rx_cnt / DIV_B;
                if (b >= 1 && b <= 8) rx_sh[b-1] = tx_b;
                else if (b == 9) begin
                    rx_q.push_back(rx_sh);
                    rx_cnt = 0;
                end
            end
            if (rx_cnt != 0) rx_cnt++;
        end
    endtask

    int ovf_seen = 0;

    // One clock on B: drive, advance model, sample and compare at negedge.
    task automatic step_b(input logic w, input logic [7:0] d, input logic r);
        wr_b = w; din_b = d; rst_b = r;
        model_edge(w, d, r);
        @(negedge clk);
        decode_b(r);
        if (ovf_b === 1'b1) ovf_seen++;
        chk("b tx/busy/full/empty/ovf", {tx_b, busy_b, full_b, empty_b, ovf_b},
            {m_tx(), rem > 0, mq.size() == DEPTH, mq.size() == 0, m_ovf});
    endtask

    task automatic drain_b(input string name);
        int g;
        g = 0;
        while ((mq.size() != 0 || rem != 0) && g < 600) begin
            step_b(1'b0, 8'h00, 1'b0);
            g++;
        end
        chk({name, " drained in budget"}, g < 600, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, g;
        tbl[0] = '{8'h55, 10'h2AA};
        tbl[1] = '{8'h00, 10'h200};
        tbl[2] = '{8'hFF, 10'h3FE};
        tbl[3] = '{8'h01, 10'h202};
        tbl[4] = '{8'h80, 10'h300};
        tbl[5] = '{8'hA5, 10'h34A};
        tbl[6] = '{8'hC3, 10'h386};

        // Reset on A, with writes offered during reset.
        rst_a = 1'b1; wr_a = 1'b1; din_a = 8'hEE;
        repeat (3) @(negedge clk);
        chk("a in reset tx/busy/empty/full/ovf", {tx_a, busy_a, empty_a, full_a, ovf_a}, 5'b10100);
        rst_a = 1'b0; wr_a = 1'b0;
        @(negedge clk);
        chk("a write in reset ignored", {empty_a, ovf_a, tx_a}, 3'b101);

        // Single frames at the default rate.
        for (int i = 0; i < 7; i++) begin
            wr_a = 1'b1; din_a = tbl[i].data;
            @(negedge clk);
            wr_a = 1'b0;
            chk("a tx high after write edge", tx_a, 1'b1);
            chk("a not empty after write", empty_a, 1'b0);
            @(negedge clk);
            run_a($sformatf("a frame %02h", tbl[i].data), 1, tbl[i].line, 10'h3FF);
        end

        // Back-to-back pair: pop of the first byte coincides with the second write.
        wr_a = 1'b1; din_a = 8'hA5;
        @(negedge clk);
        din_a = 8'h3C;
        @(negedge clk);
        wr_a = 1'b0;
        run_a("a pair a5 3c", 2, 10'h34A, 10'h278);

        // B: reset, then overflow with six consecutive writes.
        repeat (3) step_b(1'b1, 8'h00, 1'b1);
        rx_q.delete(); ovf_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            step_b(1'b1, 8'(i), 1'b0);
            if (i == 5) chk("b full after fifth write", full_b, 1'b1);
        end
        drain_b("b ovf");
        chk("b ovf pulses", ovf_seen, 1);
        chk("b ovf bytes received", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk($sformatf("b ovf byte %0d", i), rx_q[i], 8'(i + 1));

        // B: reset during data bit 3 of 0xF0 with two bytes queued.
        step_b(1'b0, 8'h00, 1'b0);
        rx_q.delete();
        step_b(1'b1, 8'hF0, 1'b0);
        step_b(1'b1, 8'hA1, 1'b0);
        step_b(1'b1, 8'hB2, 1'b0);
        repeat (11) step_b(1'b0, 8'h00, 1'b0);
        step_b(1'b0, 8'h00, 1'b1);
        chk("b after mid-frame reset tx/busy/empty", {tx_b, busy_b, empty_b}, 3'b101);
        repeat (40) step_b(1'b0, 8'h00, 1'b0);
        chk("b nothing sent after reset", rx_q.size(), 0);

        // B: stream ten bytes through the four-entry FIFO.
        rx_q.delete();
        sent = 0; g = 0;
        while (sent < 10 && g < 600) begin
            if (mq.size() < DEPTH) begin
                step_b(1'b1, 8'h10 + 8'(sent), 1'b0);
                sent++;
            end else begin
                step_b(1'b0, 8'h00, 1'b0);
            end
            g++;
        end
        chk("b stream written in budget", sent, 10);
        drain_b("b stream");
        chk("b stream count", rx_q.size(), 10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            chk($sformatf("b stream byte %0d", i), rx_q[i], 8'h10 + 8'(i));
        chk("b stream end empty/busy", {empty_b, busy_b}, 2'b10);

        // B: random writes and occasional resets.
        for (int i = 0; i < 1500; i++)
            step_b($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 199) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
